tt_um_counter_checker: RTL and testbench
========================================

Name: tt_um_counter_checker

Overview:
Receive-side companion to the team's free-running 8-bit counter tile. The block samples an external 8-bit count stream on ui_in and checks that each new value is the previous value plus one, modulo 256. It reports lock status, a per-mismatch error pulse and a saturating error count on the dedicated outputs. It sits at the far end of a chip-to-chip link and is used to qualify the counter tile's output pins and board wiring.

Parameters:
LOCK_COUNT, 4, consecutive matches required to enter LOCKED (legal 1..15)
ERR_MAX, 15, saturation value of the error counter (fits 4 bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  always 1; unused
ui_in  input  8  incoming count stream, one value per clk
uio_in  input  8  [0]=clear (sync, active-high), [1]=hold; [7:2] unused
uo_out  output  8  [0]=locked, [1]=err_pulse, [3:2]=state code, [7:4]=err_cnt
uio_out  output  8  [7:4]=good_cnt (zero-extended), [3:0]=0
uio_oe  output  8  constant 8'hF0 ([7:4] outputs, [3:0] inputs)

Behaviour:
- Reset (rst_n low, asynchronous):
  - samp_q=0, prev_q=0, both valid flags=0.
  - state=ACQUIRE, good_cnt=0, err_cnt=0, err_pulse=0.
  - uo_out=0, uio_out=0, uio_oe=F0.
- Capture, per edge with hold=0:
  - samp_q<=ui_in, samp_v<=1.
  - prev_q<=samp_q, prev_v<=samp_v.
- Compare (combinational): cmp_valid = samp_v & prev_v; match = (samp_q == prev_q+1) with 8-bit wrap, so FF->00 is a match.
- Latency: a value captured at edge E is compared against the value captured at E-1. The result is visible on the outputs after edge E+1.
- State codes: ACQUIRE=00, LOCKED=01, LOST=10; 11 is unreachable and recovers to ACQUIRE.
- FSM, evaluated only when cmp_valid:
  - ACQUIRE, match: good_cnt+1. When good_cnt+1==LOCK_COUNT, go to LOCKED and hold good_cnt=LOCK_COUNT.
  - ACQUIRE, mismatch: good_cnt=0; stay in ACQUIRE.
  - LOCKED, mismatch: go to LOST, good_cnt=0, err_cnt+1 (saturating at ERR_MAX), err_pulse=1 for exactly one cycle.
  - LOCKED, match: no change.
  - LOST, match: go to ACQUIRE with good_cnt=1. If LOCK_COUNT==1, go straight to LOCKED.
  - LOST, mismatch: stay in LOST. No further error counting; errors count once per loss event.
- err_pulse is 0 in every cycle not listed above.
- Hold (uio_in[1]=1):
  - No capture, no compare; FSM and counters are frozen.
  - samp_v and prev_v are cleared, so after release two fresh samples are needed before comparing.
- Clear (uio_in[0]=1), highest priority after reset:
  - err_cnt=0, err_pulse=0, state=ACQUIRE, good_cnt=0.
  - The capture path keeps running, unless hold is also asserted.
  - Clear coincident with a mismatch: clear wins; no pulse, no count.
- Reset mid-operation: all outputs go to 0 immediately and asynchronously; the block resumes as after power-up.
- uo_out[0] = (state==LOCKED). All outputs are driven directly from registers; there is no combinational path from ui_in to any output.

Decomposition:
- Package counter_chk_pkg holds:
  - state enum (ACQUIRE, LOCKED, LOST) with 2-bit codes
  - bit-position constants for the uo_out fields and the uio_in control bits
  - UIO_OE_MASK = 8'hF0
- Sub-module counter_chk_sampler holds samp_q/prev_q, the valid flags and the hold handling, and outputs cmp_valid and match.
- The top level holds the FSM, the counters and the output packing.

Test Plan:
1. Reset, then ui_in=0,1,2,... one value per clk with LOCK_COUNT=4 -> uo_out[0] goes to 1 after the edge following capture of value 4; uio_out[7:4]=4, uo_out[7:4]=0, uo_out[3:2]=01.
2. While locked, stream FA..FF,00,01,02 -> stays LOCKED; err_pulse is never 1 and err_cnt=0 across the wrap.
3. While locked, send 0x20 in place of 0x10, then 0x21,0x22... -> err_pulse=1 for one cycle, err_cnt=1, state LOST. Then ACQUIRE with good_cnt=1, and LOCKED after three further matches.
4. Twenty separate loss/relock events -> err_cnt saturates at 15 (uo_out[7:4]=F) and stays there; clear returns it to 0.
5. Assert clear in the same cycle a mismatch is evaluated in LOCKED -> err_cnt=0, no err_pulse, state ACQUIRE, good_cnt=0.
6. Hold for 3 cycles while ui_in jumps to random values, then resume the correct sequence -> no error, state unchanged.
   Then assert rst_n=0 mid-LOCKED -> uo_out=0 and uio_out=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/counter_chk_pkg.sv
// Shared types, field positions and helpers for the counter-stream checker.
package counter_chk_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    // Lock-tracking state; 2'b11 is unused and recovers to ACQUIRE.
    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        LOCKED  = 2'b01,
        LOST    = 2'b10
    } state_e;

    // uo_out field positions
    localparam int unsigned UO_LOCKED_BIT    = 0;
    localparam int unsigned UO_ERR_PULSE_BIT = 1;
    localparam int unsigned UO_STATE_LSB     = 2;
    localparam int unsigned UO_ERR_CNT_LSB   = 4;

    // uio_in control bits and uio_out field position
    localparam int unsigned UIO_CLEAR_BIT = 0;
    localparam int unsigned UIO_HOLD_BIT  = 1;
    localparam int unsigned UIO_GOOD_LSB  = 4;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // Increment that sticks at lim once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : CNT_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/counter_chk_if.sv
// Link between the FSM top and the sampler: sample stream in, compare result out.
interface counter_chk_if;
    import counter_chk_pkg::*;

    logic [DATA_W-1:0] data;
    logic              hold;
    logic              cmp_valid_c;
    logic              match_c;

    modport master (
        output data,
        output hold,
        input  cmp_valid_c,
        input  match_c
    );

    modport slave (
        input  data,
        input  hold,
        output cmp_valid_c,
        output match_c
    );

endinterface

// File: rtl/counter_chk_sampler.sv
// Two-deep capture of the count stream and the +1 (mod 256) comparison.
module counter_chk_sampler
    import counter_chk_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    counter_chk_if.slave  lnk
);

    logic [DATA_W-1:0] samp_q;
    logic [DATA_W-1:0] prev_q;
    logic              samp_v;
    logic              prev_v;

    // Shift a new sample in each cycle; hold drops both valids so two fresh samples are needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            prev_q <= '0;
            samp_v <= 1'b0;
            prev_v <= 1'b0;
        end else if (lnk.hold) begin
            samp_v <= 1'b0;
            prev_v <= 1'b0;
        end else begin
            samp_q <= lnk.data;
            samp_v <= 1'b1;
            prev_q <= samp_q;
            prev_v <= samp_v;
        end
    end

    // Compare newest sample against the previous one; FF->00 wraps and counts as a match.
    assign lnk.cmp_valid_c = samp_v & prev_v;
    assign lnk.match_c     = (samp_q == DATA_W'(prev_q + 1'b1));

endmodule

// File: rtl/tt_um_counter_checker.sv
// Checks an incoming 8-bit count stream for +1 continuity; reports lock, error pulse and counts.
module tt_um_counter_checker
    import counter_chk_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_MAX    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] LOCK_CNT_V = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] ERR_MAX_V  = CNT_W'(ERR_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             locked_q, locked_d;

    logic clear;
    logic hold;
    logic unused_c;

    assign clear    = uio_in[UIO_CLEAR_BIT];
    assign hold     = uio_in[UIO_HOLD_BIT];
    assign unused_c = ^{ena, uio_in[7:2]};

    counter_chk_if lnk ();

    assign lnk.data = ui_in;
    assign lnk.hold = hold;

    counter_chk_sampler u_sampler (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (lnk.slave)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACQUIRE;
            good_q   <= '0;
            err_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
        end
    end

    // Next-state: clear wins, hold freezes, otherwise step only on a valid compare.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        pulse_d = 1'b0;

        if (clear) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_d   = '0;
        end else if (!hold) begin
            case (state_q)
                ACQUIRE: begin
                    if (lnk.cmp_valid_c) begin
                        if (lnk.match_c) begin
                            if (CNT_W'(good_q + 1'b1) == LOCK_CNT_V) begin
                                state_d = LOCKED;
                                good_d  = LOCK_CNT_V;
                            end else begin
                                good_d = CNT_W'(good_q + 1'b1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lnk.cmp_valid_c && !lnk.match_c) begin
                        state_d = LOST;
                        good_d  = '0;
                        err_d   = sat_inc(err_q, ERR_MAX_V);
                        pulse_d = 1'b1;
                    end
                end
                LOST: begin
                    if (lnk.cmp_valid_c && lnk.match_c) begin
                        state_d = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                        good_d  = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // Pack register fields onto uo_out.
    always_comb begin
        uo_out                              = '0;
        uo_out[UO_LOCKED_BIT]               = locked_q;
        uo_out[UO_ERR_PULSE_BIT]            = pulse_q;
        uo_out[UO_STATE_LSB +: 2]           = state_q;
        uo_out[UO_ERR_CNT_LSB +: CNT_W]     = err_q;
    end

    // Good-match count on the upper bidirectional pins.
    always_comb begin
        uio_out                         = '0;
        uio_out[UIO_GOOD_LSB +: CNT_W]  = good_q;
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_counter_checker.sv
// Directed bench for the counter-stream checker: vector table plus corner-case sequences.
module tb_tt_um_counter_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] cur;
    logic [7:0] pre;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] ctl;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[14];

    tt_um_counter_checker #(.LOCK_COUNT(4), .ERR_MAX(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    // Drive one value on the falling edge, then sample 1ns after the rising edge.
    task automatic step(input logic [7:0] v, input logic [7:0] ctl);
        @(negedge clk);
        ui_in  = v;
        uio_in = ctl;
        @(posedge clk);
        #1;
        cur = v;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].ui, vecs[i].ctl);
            check($sformatf("vec%0d uo_out", i), uo_out, vecs[i].exp_uo);
            check($sformatf("vec%0d uio_out", i), uio_out, vecs[i].exp_uio);
        end
    endtask

    function automatic logic [7:0] uo_exp(input int err, input logic [1:0] st, input logic pulse);
        logic [3:0] e;
        e = (err > 15) ? 4'd15 : 4'(err);
        return {e, st, pulse, (st == 2'b01)};
    endfunction

    initial begin
        // Power-up lock sequence: 0,1,2,... -> locked after the edge following capture of 4
        vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{8'h01, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{8'h02, 8'h00, 8'h00, 8'h10};
        vecs[3]  = '{8'h03, 8'h00, 8'h00, 8'h20};
        vecs[4]  = '{8'h04, 8'h00, 8'h00, 8'h30};
        vecs[5]  = '{8'h05, 8'h00, 8'h05, 8'h40};
        vecs[6]  = '{8'h06, 8'h00, 8'h05, 8'h40};
        // Loss at 0x20-for-0x10, then relock on 0x21.. (preceded by ..0x0F)
        vecs[7]  = '{8'h20, 8'h00, 8'h05, 8'h40};
        vecs[8]  = '{8'h21, 8'h00, 8'h1A, 8'h00};
        vecs[9]  = '{8'h22, 8'h00, 8'h10, 8'h10};
        vecs[10] = '{8'h23, 8'h00, 8'h10, 8'h20};
        vecs[11] = '{8'h24, 8'h00, 8'h10, 8'h30};
        vecs[12] = '{8'h25, 8'h00, 8'h15, 8'h40};
        vecs[13] = '{8'h26, 8'h00, 8'h15, 8'h40};

        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        cur    = 8'h00;
        #12;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire and lock
        run_vecs(0, 6);

        // Stay locked across the FF->00 wrap
        for (int i = 7; i <= 16'h10F; i++) begin
            step(8'(i), 8'h00);
            check($sformatf("wrap uo_out v=%02h", 8'(i)), uo_out, 8'h05);
            check($sformatf("wrap uio_out v=%02h", 8'(i)), uio_out, 8'h40);
        end

        // Single loss event and relock
        run_vecs(7, 13);

        // Twenty more loss/relock events; error count saturates at 15
        for (int k = 1; k <= 20; k++) begin
            step(cur + 8'h10, 8'h00);
            check($sformatf("ev%0d jump uo_out", k), uo_out, uo_exp(k, 2'b01, 1'b0));
            step(cur + 8'd1, 8'h00);
            check($sformatf("ev%0d lost uo_out", k), uo_out, uo_exp(k + 1, 2'b10, 1'b1));
            step(cur + 8'd1, 8'h00);
            check($sformatf("ev%0d acq uo_out", k), uo_out, uo_exp(k + 1, 2'b00, 1'b0));
            check($sformatf("ev%0d acq uio_out", k), uio_out, 8'h10);
            for (int j = 0; j < 3; j++) step(cur + 8'd1, 8'h00);
            check($sformatf("ev%0d relock uo_out", k), uo_out, uo_exp(k + 1, 2'b01, 1'b0));
            check($sformatf("ev%0d relock uio_out", k), uio_out, 8'h40);
        end
        check("saturated err_cnt", uo_out, 8'hF5);

        // Clear resets counters and state; capture keeps running
        step(cur + 8'd1, 8'h01);
        check("clear uo_out", uo_out, 8'h00);
        check("clear uio_out", uio_out, 8'h00);
        for (int j = 0; j < 4; j++) step(cur + 8'd1, 8'h00);
        check("post-clear relock uo_out", uo_out, 8'h05);
        check("post-clear relock uio_out", uio_out, 8'h40);

        // Clear coincident with a LOCKED mismatch: no pulse, no count
        step(cur + 8'h10, 8'h00);
        check("clr+mis jump uo_out", uo_out, 8'h05);
        step(cur + 8'd1, 8'h01);
        check("clr+mis uo_out", uo_out, 8'h00);
        check("clr+mis uio_out", uio_out, 8'h00);
        step(cur + 8'd1, 8'h00);
        check("clr+mis next uo_out", uo_out, 8'h00);
        check("clr+mis next uio_out", uio_out, 8'h10);
        for (int j = 0; j < 3; j++) step(cur + 8'd1, 8'h00);
        check("clr+mis relock uo_out", uo_out, 8'h05);

        // Hold with junk on ui_in, then resume at a new base; no compare spans the hold
        pre = cur;
        for (int j = 0; j < 3; j++) begin
            step(8'($urandom_range(0, 255)), 8'h02);
            check($sformatf("hold%0d uo_out", j), uo_out, 8'h05);
            check($sformatf("hold%0d uio_out", j), uio_out, 8'h40);
        end
        step(pre + 8'h40, 8'h00);
        for (int j = 0; j < 4; j++) begin
            step(cur + 8'd1, 8'h00);
            check($sformatf("resume%0d uo_out", j), uo_out, 8'h05);
            check($sformatf("resume%0d uio_out", j), uio_out, 8'h40);
        end

        // Asynchronous reset mid-LOCKED, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst uo_out", uo_out, 8'h00);
        check("async rst uio_out", uio_out, 8'h00);
        check("async rst uio_oe", uio_oe, 8'hF0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vecs(0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
